// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit accumulator CPU.
//   - fetch sequencer state encoding (IDLE/RUN/HALT, 2 bits)
//   - default PC width and branch look-up table depth
//   - constant branch target table used by branch_lut
package cpu_pkg;

  localparam int unsigned PC_W_DEFAULT = 10;
  localparam int unsigned LUT_DEPTH    = 16;
  localparam int unsigned LUT_IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Absolute branch targets, indexed by the 4-bit branch operand.
  // Callers truncate to their PC width.
  function automatic int unsigned branch_target(input logic [LUT_IDX_W-1:0] idx);
    int unsigned t;
    case (idx)
      4'd0:    t = 100;
      4'd1:    t = 200;
      4'd2:    t = 300;
      4'd3:    t = 350;
      4'd4:    t = 17;
      4'd5:    t = 512;
      4'd6:    t = 640;
      4'd7:    t = 700;
      4'd8:    t = 750;
      4'd9:    t = 800;
      4'd10:   t = 850;
      4'd11:   t = 900;
      4'd12:   t = 950;
      4'd13:   t = 1000;
      4'd14:   t = 20;
      default: t = 40;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch target table (LUT_DEPTH entries x PC_W bits).
// Ports:
//   i_idx     in  4     table index (branch operand, Instruction[3:0])
//   o_target  out PC_W  absolute branch target
module branch_lut
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [LUT_IDX_W-1:0] i_idx,
  output logic [PC_W-1:0]      o_target
);

  always_comb begin
    o_target = PC_W'(branch_target(i_idx));
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch sequencer for the 9-bit accumulator CPU.
// Drives PC into the instruction ROM, applies decoder branch/halt requests and
// runs the Req/Done program-start handshake.
// Ports:
//   CLK          in   1      clock, rising edge
//   Reset        in   1      synchronous active-high reset
//   Req          in   1      start request (honoured in IDLE/HALT only)
//   Instruction  in   9      ROM word at PC; [3:0] is the branch operand
//   BranchEn     in   1      current instruction is a branch
//   LookUp       in   1      branch target from LUT (1) or PC-relative (0)
//   Ack          in   1      current instruction is halt
//   Taken        in   1      branch condition true
//   PC           out  PC_W   instruction address
//   Running      out  1      in RUN
//   Done         out  1      in HALT
//   Fault        out  1      halt forced by running off end of ROM
//   CycleCnt     out  CNT_W  instructions fetched since last start (saturating)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEFAULT,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Req,
  input  logic [8:0]       Instruction,
  input  logic             BranchEn,
  input  logic             LookUp,
  input  logic             Ack,
  input  logic             Taken,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] CycleCnt
);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic             r_running;
  logic             r_done;

  state_t           w_state_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fault_nxt;
  logic [PC_W-1:0]  w_lut_target;
  logic [PC_W-1:0]  w_rel_off;
  logic             w_br_taken;
  logic             w_unused_opcode;

  // Opcode bits are decoded elsewhere; only the operand nibble matters here.
  assign w_unused_opcode = ^Instruction[8:4];

  branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .i_idx    (Instruction[3:0]),
    .o_target (w_lut_target)
  );

  // Sign-extended 4-bit relative offset (-8..+7); the add wraps modulo 2**PC_W.
  assign w_rel_off  = {{(PC_W-4){Instruction[3]}}, Instruction[3:0]};
  assign w_br_taken = BranchEn & Taken;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    case (r_state)
      IDLE, HALT: begin
        if (Req) begin
          w_state_nxt = RUN;
          w_pc_nxt    = PC_W'(START_ADDR);
          w_cnt_nxt   = '0;
          w_fault_nxt = 1'b0;
        end
      end
      RUN: begin
        if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (Ack) begin
          w_state_nxt = HALT;
        end else if (w_br_taken && LookUp) begin
          w_pc_nxt = w_lut_target;
        end else if (w_br_taken) begin
          w_pc_nxt = r_pc + w_rel_off;
        end else if (r_pc == '1) begin
          // Falling off the last ROM word: stop rather than wrap to 0.
          w_state_nxt = HALT;
          w_fault_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fault   <= w_fault_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == HALT);
    end
  end

  assign PC       = r_pc;
  assign Running  = r_running;
  assign Done     = r_done;
  assign Fault    = r_fault;
  assign CycleCnt = r_cnt;

endmodule
